// File: rtl/scoreboard_hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// scoreboard_hazard_unit_pkg
//   Shared constants, types and helpers for the register scoreboard.
//   - SB_* constants: default sizing of the scoreboard (registers, latency).
//   - LAT_VARIABLE: latency code of a variable-latency producer. Such a
//     producer finishes through the completion port.
//   - lat_onehot / row_index / clamp_lat: conversions between a latency value
//     and a one-hot writeback-countdown row.
//   The helper widths follow the SB_* constants. The top-level parameters
//   default to these values and are expected to keep them.
// -----------------------------------------------------------------------------
package scoreboard_hazard_unit_pkg;

  localparam int SB_NUM_REGS = 32;
  localparam int SB_REG_W    = 5;
  localparam int SB_MAX_LAT  = 5;
  localparam int SB_LAT_W    = 3;

  typedef logic [SB_LAT_W-1:0]   lat_t;
  typedef logic [SB_MAX_LAT-1:0] wb_row_t;
  typedef logic [SB_REG_W-1:0]   reg_idx_t;

  // Latency code 0 marks a producer whose writeback time is unknown at issue.
  localparam lat_t LAT_VARIABLE = '0;

  // Breakdown of why issue is blocked.
  typedef struct packed {
    logic raw;      // a checked source is not yet readable or forwardable
    logic waw;      // an older write to rd would land at or after this one
    logic wb_port;  // the writeback slot for this latency is already taken
  } hazard_t;

  // An out-of-range latency is treated as the longest legal fixed latency.
  function automatic lat_t clamp_lat(input lat_t lat);
    return (lat > lat_t'(SB_MAX_LAT)) ? lat_t'(SB_MAX_LAT) : lat;
  endfunction

  // Fixed latency L becomes a one-hot row with bit L-1 set. The row holds
  // "cycles until writeback" as seen from the cycle after issue.
  // LAT_VARIABLE maps to an all-zero row.
  function automatic wb_row_t lat_onehot(input lat_t lat);
    wb_row_t oh;
    oh = '0;
    for (int k = 0; k < SB_MAX_LAT; k++) begin
      if (lat == lat_t'(k + 1)) oh[k] = 1'b1;
    end
    return oh;
  endfunction

  // Returns the position of the set bit in a one-hot row, or 0 for an
  // empty row.
  function automatic lat_t row_index(input wb_row_t row);
    lat_t idx;
    idx = '0;
    for (int k = 0; k < SB_MAX_LAT; k++) begin
      if (row[k]) idx = lat_t'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scoreboard_hazard_unit_row.sv
// -----------------------------------------------------------------------------
// scoreboard_row
//   Scoreboard state for one architectural register: the pending flag and
//   the one-hot writeback-countdown row.
//   Ports:
//     clock_i      system clock
//     reset_i      synchronous, active-high; clears pend and row
//     flush_i      synchronous squash; clears pend and row
//     alloc_i      a new producer for this register issues this cycle
//     alloc_row_i  countdown row to load on allocation (0 = variable latency)
//     cpl_i        the completion port names this register this cycle
//     pend_o       register has an outstanding write
//     row_o        writeback countdown; bit k = writeback k cycles from now
// -----------------------------------------------------------------------------
module scoreboard_row
  import scoreboard_hazard_unit_pkg::*;
#(
  parameter int MAX_LAT = SB_MAX_LAT
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               flush_i,
  input  logic               alloc_i,
  input  logic [MAX_LAT-1:0] alloc_row_i,
  input  logic               cpl_i,
  output logic               pend_o,
  output logic [MAX_LAT-1:0] row_o
);

  logic               pend_q, pend_d;
  logic [MAX_LAT-1:0] row_q,  row_d;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    pend_d = pend_q;
    row_d  = row_q >> 1;

    // A fixed-latency writeback happens this cycle, so the register is free
    // from the next cycle on.
    if (pend_q && row_q[0]) pend_d = 1'b0;

    // A completion only retires a variable-latency entry (empty row).
    // Completions that name a fixed-latency or idle register are ignored.
    if (pend_q && (row_q == '0) && cpl_i) pend_d = 1'b0;

    // A new producer takes precedence over both retirements above.
    if (alloc_i) begin
      pend_d = 1'b1;
      row_d  = alloc_row_i;
    end
  end

  always_ff @(posedge clock_i) begin
    // NOTE: sequential state uses non-blocking assignments only. The
    // countdown row is a handful of flops rather than a RAM, so it is cleared
    // on reset and flush together with the pending flag.
    if (reset_i || flush_i) begin
      pend_q <= 1'b0;
      row_q  <= '0;
    end else begin
      pend_q <= pend_d;
      row_q  <= row_d;
    end
  end

  assign pend_o = pend_q;
  assign row_o  = row_q;

  // The row is one-hot or empty. It can only be non-empty while pending.
  row_shape_a: assert property (@(posedge clock_i) disable iff (reset_i)
    $onehot0(row_q) && (pend_q || (row_q == '0)));

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// -----------------------------------------------------------------------------
// scoreboard_hazard_unit
//   Register scoreboard and issue-stall generation. It covers RAW hazards on
//   NUM_SRC sources, WAW hazards on the destination, and the shared
//   writeback-port structural hazard. It handles fixed-latency producers
//   (1..MAX_LAT) and variable-latency producers (latency 0) that finish
//   through the completion port.
//   Ports:
//     clock            system clock
//     reset            synchronous, active-high; clears all state
//     flush            synchronous squash; clears all pending state
//     issue_valid      an instruction is presented for issue
//     issue_src        NUM_SRC packed source indices (source i at i*REG_W)
//     issue_src_check  per-source check enable
//     issue_writes     instruction writes issue_rd
//     issue_rd         destination register
//     issue_lat        1..MAX_LAT fixed latency, 0 = variable latency
//     cpl_valid        variable-latency completion this cycle
//     cpl_rd           register being completed
//     stall            issue blocked this cycle (combinational)
//     src_fwd          per source: operand comes from the bypass network
//     busy             registered pending vector (bit 0 always 0)
//     wb_column        registered writeback-slot occupancy, bit k = k cycles
// -----------------------------------------------------------------------------
module scoreboard_hazard_unit
  import scoreboard_hazard_unit_pkg::*;
#(
  parameter int NUM_REGS = SB_NUM_REGS,
  parameter int REG_W    = SB_REG_W,
  parameter int NUM_SRC  = 2,
  parameter int MAX_LAT  = SB_MAX_LAT,
  parameter int LAT_W    = SB_LAT_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     issue_valid,
  input  logic [NUM_SRC*REG_W-1:0] issue_src,
  input  logic [NUM_SRC-1:0]       issue_src_check,
  input  logic                     issue_writes,
  input  logic [REG_W-1:0]         issue_rd,
  input  logic [LAT_W-1:0]         issue_lat,
  input  logic                     cpl_valid,
  input  logic [REG_W-1:0]         cpl_rd,
  output logic                     stall,
  output logic [NUM_SRC-1:0]       src_fwd,
  output logic [NUM_REGS-1:0]      busy,
  output logic [MAX_LAT-1:0]       wb_column
);

  // ---------------------------------------------------------------------------
  // Per-register state
  // ---------------------------------------------------------------------------
  logic [NUM_REGS-1:0] pend;
  logic [MAX_LAT-1:0]  row [NUM_REGS];
  logic [LAT_W-1:0]    lat_eff;
  logic [MAX_LAT-1:0]  alloc_row;
  logic                alloc;

  assign lat_eff   = clamp_lat(issue_lat);
  assign alloc_row = lat_onehot(lat_eff);

  // Register 0 is hard-wired idle: it never allocates and never stalls.
  assign pend[0] = 1'b0;
  assign row[0]  = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_row
    scoreboard_row #(
      .MAX_LAT (MAX_LAT)
    ) u_row (
      .clock_i     (clock),
      .reset_i     (reset),
      .flush_i     (flush),
      .alloc_i     (alloc && (issue_rd == REG_W'(r))),
      .alloc_row_i (alloc_row),
      .cpl_i       (cpl_valid && (cpl_rd == REG_W'(r))),
      .pend_o      (pend[r]),
      .row_o       (row[r])
    );
  end

  // ---------------------------------------------------------------------------
  // Writeback-slot column: bit k means a fixed-latency result is already
  // scheduled to use the writeback port k cycles from now.
  // ---------------------------------------------------------------------------
  logic [MAX_LAT-1:0] col_q, col_d;

  // Variable-latency producers arbitrate for the port themselves. Their
  // alloc_row is all-zero, so they reserve no slot here.
  assign col_d = (col_q >> 1) | (alloc ? alloc_row : '0);

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      col_q <= '0;
    end else begin
      col_q <= col_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Source (RAW) hazards and forwarding
  // ---------------------------------------------------------------------------
  logic [REG_W-1:0]   src_idx [NUM_SRC];
  logic [NUM_SRC-1:0] src_haz;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_idx[i] = issue_src[i*REG_W +: REG_W];
  end

  always_comb begin
    src_haz = '0;
    src_fwd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (issue_src_check[i] && (src_idx[i] != '0) && pend[src_idx[i]]) begin
        // The operand is usable this cycle when it is written back now
        // (row == 1). It is also usable when a variable-latency producer
        // completes on the port in this same cycle. In both cases the value
        // is only on the bypass network.
        if (row[src_idx[i]] == MAX_LAT'(1)) begin
          src_fwd[i] = 1'b1;
        end else if ((row[src_idx[i]] == '0) && cpl_valid &&
                     (cpl_rd == src_idx[i])) begin
          src_fwd[i] = 1'b1;
        end else begin
          src_haz[i] = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // WAW and structural hazards
  // ---------------------------------------------------------------------------
  logic [MAX_LAT-1:0] rd_row;
  logic               waw;
  logic               wb_conflict;
  hazard_t            haz;

  assign rd_row = row[issue_rd];

  always_comb begin
    waw = 1'b0;
    if (issue_writes && (issue_rd != '0) && pend[issue_rd]) begin
      if (lat_eff == LAT_VARIABLE) begin
        // The new write has no known time. It is only safe when the old
        // write lands this very cycle.
        waw = (rd_row != MAX_LAT'(1));
      end else begin
        // The old write must land strictly before the new one. An old
        // variable-latency write (empty row) is never known to do so.
        waw = (rd_row == '0) || (row_index(rd_row) >= lat_eff);
      end
    end
  end

  // MAX_LAT has no column bit, because nothing can already be booked that
  // far out. Only latencies 1..MAX_LAT-1 can collide.
  always_comb begin
    wb_conflict = 1'b0;
    for (int k = 1; k < MAX_LAT; k++) begin
      if (issue_writes && (lat_eff == LAT_W'(k)) && col_q[k]) wb_conflict = 1'b1;
    end
  end

  assign haz.raw     = |src_haz;
  assign haz.waw     = waw;
  assign haz.wb_port = wb_conflict;

  assign stall = issue_valid && (|haz);
  assign alloc = issue_valid && !stall && issue_writes && (issue_rd != '0);

  assign busy      = pend;
  assign wb_column = col_q;

  // Latencies above MAX_LAT are illegal. The logic above clamps them.
  lat_legal_a: assert property (@(posedge clock) disable iff (reset)
    issue_valid |-> (issue_lat <= LAT_W'(MAX_LAT)));

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_scoreboard_hazard_unit
//   Directed scenarios followed by randomized traffic. Every cycle the DUT is
//   compared against a reference model. The model tracks, for each register,
//   whether it is pending and the absolute cycle of its writeback. It also
//   keeps the set of absolute cycles already booked on the writeback port.
// -----------------------------------------------------------------------------
module tb_scoreboard_hazard_unit;

  localparam int NUM_REGS = 32;
  localparam int REG_W    = 5;
  localparam int NUM_SRC  = 2;
  localparam int MAX_LAT  = 5;
  localparam int LAT_W    = 3;

  logic                     clock;
  logic                     reset;
  logic                     flush;
  logic                     issue_valid;
  logic [NUM_SRC*REG_W-1:0] issue_src;
  logic [NUM_SRC-1:0]       issue_src_check;
  logic                     issue_writes;
  logic [REG_W-1:0]         issue_rd;
  logic [LAT_W-1:0]         issue_lat;
  logic                     cpl_valid;
  logic [REG_W-1:0]         cpl_rd;
  logic                     stall;
  logic [NUM_SRC-1:0]       src_fwd;
  logic [NUM_REGS-1:0]      busy;
  logic [MAX_LAT-1:0]       wb_column;

  scoreboard_hazard_unit #(
    .NUM_REGS (NUM_REGS),
    .REG_W    (REG_W),
    .NUM_SRC  (NUM_SRC),
    .MAX_LAT  (MAX_LAT),
    .LAT_W    (LAT_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .issue_valid     (issue_valid),
    .issue_src       (issue_src),
    .issue_src_check (issue_src_check),
    .issue_writes    (issue_writes),
    .issue_rd        (issue_rd),
    .issue_lat       (issue_lat),
    .cpl_valid       (cpl_valid),
    .cpl_rd          (cpl_rd),
    .stall           (stall),
    .src_fwd         (src_fwd),
    .busy            (busy),
    .wb_column       (wb_column)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit m_pend [NUM_REGS];
  bit m_var  [NUM_REGS];
  int m_wb   [NUM_REGS];   // absolute cycle of a fixed-latency writeback
  bit booked [int];        // absolute cycles with the writeback port taken
  int now = 0;

  function automatic int src_of(int i);
    return int'(issue_src[i*REG_W +: REG_W]);
  endfunction

  function automatic bit m_src_haz(int i);
    int s;
    s = src_of(i);
    if (!issue_src_check[i] || s == 0 || !m_pend[s]) return 1'b0;
    if (!m_var[s]) return (m_wb[s] - now) != 0;
    return !(cpl_valid && int'(cpl_rd) == s);
  endfunction

  function automatic bit m_fwd(int i);
    int s;
    s = src_of(i);
    return issue_src_check[i] && s != 0 && m_pend[s] && !m_src_haz(i);
  endfunction

  function automatic bit m_waw();
    int rd;
    int lat;
    int rem;
    rd  = int'(issue_rd);
    lat = int'(issue_lat);
    if (!issue_writes || rd == 0 || !m_pend[rd]) return 1'b0;
    if (m_var[rd]) return 1'b1;
    rem = m_wb[rd] - now;
    if (lat == 0) return rem != 0;
    return rem >= lat;
  endfunction

  function automatic bit m_wbport();
    int lat;
    lat = int'(issue_lat);
    return issue_writes && lat > 0 && lat < MAX_LAT && booked.exists(now + lat);
  endfunction

  function automatic bit m_stall();
    bit h;
    h = m_waw() || m_wbport();
    for (int i = 0; i < NUM_SRC; i++) if (m_src_haz(i)) h = 1'b1;
    return issue_valid && h;
  endfunction

  function automatic logic [NUM_REGS-1:0] m_busy();
    logic [NUM_REGS-1:0] b;
    for (int r = 0; r < NUM_REGS; r++) b[r] = m_pend[r];
    return b;
  endfunction

  function automatic logic [MAX_LAT-1:0] m_col();
    logic [MAX_LAT-1:0] c;
    for (int j = 0; j < MAX_LAT; j++) c[j] = booked.exists(now + j);
    return c;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < NUM_REGS; r++) begin
      m_pend[r] = 1'b0;
      m_var[r]  = 1'b0;
      m_wb[r]   = 0;
    end
    booked.delete();
  endtask

  // Advance the model by one clock edge, using the inputs applied this cycle.
  task automatic m_update();
    bit alloc;
    int rd;
    int lat;
    alloc = issue_valid && !m_stall() && issue_writes && issue_rd != 0;
    rd    = int'(issue_rd);
    lat   = int'(issue_lat);
    if (reset || flush) begin
      m_clear();
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        if (m_pend[r] && !m_var[r] && m_wb[r] == now) m_pend[r] = 1'b0;
      if (cpl_valid && m_pend[cpl_rd] && m_var[cpl_rd]) m_pend[cpl_rd] = 1'b0;
      if (alloc) begin
        m_pend[rd] = 1'b1;
        m_var[rd]  = (lat == 0);
        m_wb[rd]   = now + lat;
        if (lat > 0) booked[now + lat] = 1'b1;
      end
    end
    now++;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  logic                stall_s;
  logic [NUM_SRC-1:0]  fwd_s;
  logic [NUM_REGS-1:0] busy_s;
  logic [MAX_LAT-1:0]  col_s;

  task automatic drive(input bit v, input int s0, input int s1, input bit [1:0] chk,
                       input bit wr, input int rd, input int lat,
                       input bit cv, input int crd, input bit fl);
    issue_valid     = v;
    issue_src       = {REG_W'(s1), REG_W'(s0)};
    issue_src_check = chk;
    issue_writes    = wr;
    issue_rd        = REG_W'(rd);
    issue_lat       = LAT_W'(lat);
    cpl_valid       = cv;
    cpl_rd          = REG_W'(crd);
    flush           = fl;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 2'b00, 1'b0, 0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_flush();
    drive(1'b0, 0, 0, 2'b00, 1'b0, 0, 0, 1'b0, 0, 1'b1);
    step();
  endtask

  // Compare the current cycle against the model at the falling edge, then
  // let the rising edge advance both the DUT and the model.
  task automatic step();
    @(negedge clock);
    stall_s = stall;
    fwd_s   = src_fwd;
    busy_s  = busy;
    col_s   = wb_column;
    check("stall", stall, m_stall());
    for (int i = 0; i < NUM_SRC; i++)
      if (issue_src_check[i]) check($sformatf("src_fwd%0d", i), src_fwd[i], m_fwd(i));
    check("busy", busy, m_busy());
    check("wb_column", wb_column, m_col());
    @(posedge clock);
    m_update();
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clock);
    #1;
    m_clear();
    now   = 0;
    reset = 1'b0;

    // Reset state
    step();
    check("rst_busy", busy_s, '0);
    check("rst_col", col_s, '0);
    check("rst_stall", stall_s, 1'b0);

    // Fixed latency 3 on r5: the reader stalls twice, then forwards.
    drive(1'b1, 0, 0, 2'b00, 1'b1, 5, 3, 1'b0, 0, 1'b0);
    step();
    check("tp1_issue", stall_s, 1'b0);
    drive(1'b1, 5, 0, 2'b01, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    step();
    check("tp1_stall_a", stall_s, 1'b1);
    step();
    check("tp1_stall_b", stall_s, 1'b1);
    step();
    check("tp1_go", stall_s, 1'b0);
    check("tp1_fwd", fwd_s[0], 1'b1);
    idle();
    step();
    check("tp1_free", busy_s[5], 1'b0);

    // Variable latency on r7: the reader waits until the completion cycle.
    drive(1'b1, 0, 0, 2'b00, 1'b1, 7, 0, 1'b0, 0, 1'b0);
    step();
    drive(1'b1, 7, 0, 2'b01, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      step();
      check("tp2_wait", stall_s, 1'b1);
    end
    drive(1'b1, 7, 0, 2'b01, 1'b0, 0, 0, 1'b1, 7, 1'b0);
    step();
    check("tp2_cpl_go", stall_s, 1'b0);
    check("tp2_cpl_fwd", fwd_s[0], 1'b1);
    idle();
    step();
    check("tp2_free", busy_s[7], 1'b0);

    // WAW on r3: L=2 behind k=3 stalls, L=5 behind k=3 does not.
    do_flush();
    drive(1'b1, 0, 0, 2'b00, 1'b1, 3, 4, 1'b0, 0, 1'b0);
    step();
    drive(1'b1, 0, 0, 2'b00, 1'b1, 3, 2, 1'b0, 0, 1'b0);
    step();
    check("tp3_waw", stall_s, 1'b1);
    do_flush();
    drive(1'b1, 0, 0, 2'b00, 1'b1, 3, 4, 1'b0, 0, 1'b0);
    step();
    drive(1'b1, 0, 0, 2'b00, 1'b1, 3, 5, 1'b0, 0, 1'b0);
    step();
    check("tp3_nowaw", stall_s, 1'b0);

    // Writeback port collision: r1 L=3, then r2 L=2 one cycle later.
    do_flush();
    drive(1'b1, 0, 0, 2'b00, 1'b1, 1, 3, 1'b0, 0, 1'b0);
    step();
    drive(1'b1, 0, 0, 2'b00, 1'b1, 2, 2, 1'b0, 0, 1'b0);
    step();
    check("tp4_col2", col_s[2], 1'b1);
    check("tp4_stall", stall_s, 1'b1);
    step();
    check("tp4_go", stall_s, 1'b0);

    // r0 is never pending and never stalls.
    do_flush();
    drive(1'b1, 0, 0, 2'b00, 1'b1, 0, 1, 1'b0, 0, 1'b0);
    step();
    check("tp5_issue", stall_s, 1'b0);
    drive(1'b1, 0, 0, 2'b01, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      step();
      check("tp5_stall", stall_s, 1'b0);
      check("tp5_busy", busy_s, '0);
    end

    // Flush with four registers pending and an issue in the flush cycle.
    do_flush();
    drive(1'b1, 0, 0, 2'b00, 1'b1, 10, 5, 1'b0, 0, 1'b0); step();
    drive(1'b1, 0, 0, 2'b00, 1'b1, 11, 0, 1'b0, 0, 1'b0); step();
    drive(1'b1, 0, 0, 2'b00, 1'b1, 12, 2, 1'b0, 0, 1'b0); step();
    drive(1'b1, 0, 0, 2'b00, 1'b1, 13, 0, 1'b0, 0, 1'b0); step();
    drive(1'b1, 0, 0, 2'b00, 1'b1, 14, 3, 1'b0, 0, 1'b1); step();
    check("tp6_pending", 64'($countones(busy_s)), 64'd4);
    idle();
    step();
    check("tp6_busy", busy_s, '0);
    check("tp6_col", col_s, '0);

    // Randomized traffic on a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(9, 0) < 7,
            $urandom_range(7, 0), $urandom_range(7, 0), 2'($urandom),
            $urandom_range(9, 0) < 8, $urandom_range(7, 0),
            $urandom_range(MAX_LAT, 0),
            $urandom_range(9, 0) < 3, $urandom_range(7, 0),
            $urandom_range(63, 0) == 0);
      reset = ($urandom_range(199, 0) == 0);
      step();
    end
    reset = 1'b0;
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
